// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   state_t          controller states
//   POST_RESET_BITS  quiet bit periods driven high after reset
//   DATA_BITS_*      encodings of data_bits_i
//   data_bit_count() maps data_bits_i to the number of data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    ST_POST_RESET = 2'd0,
    ST_IDLE       = 2'd1,
    ST_SEND       = 2'd2,
    ST_BREAK      = 2'd3
  } state_t;

  localparam int POST_RESET_BITS = 12;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  function automatic logic [3:0] data_bit_count(input logic [1:0] sel);
    case (sel)
      DATA_BITS_5: return 4'd5;
      DATA_BITS_6: return 4'd6;
      DATA_BITS_7: return 4'd7;
      default:     return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: byte-write bus between the register front end and the
// buffered transmitter.
//   write_i     level-qualified write strobe (one byte per high cycle)
//   data_i      byte to enqueue
//   full_o      FIFO full
//   level_o     FIFO occupancy
//   overflow_o  one-cycle pulse on a dropped write
// master = front end, slave = transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               write_i;
  logic [7:0]         data_i;
  logic               full_o;
  logic [LEVEL_W-1:0] level_o;
  logic               overflow_o;

  modport master (output write_i, data_i, input full_o, level_o, overflow_o);
  modport slave  (input write_i, data_i, output full_o, level_o, overflow_o);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, DEPTH a power of two >= 2.
//   clock_i, reset_n_i  clock, async active-low reset (flushes pointers/level)
//   push, push_data     enqueue; accepted when not full, or when full with a
//                       pop in the same cycle
//   pop, pop_data       dequeue; pop_data shows the head combinationally
//   full, empty, level  occupancy status, all derived from registered state
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_ok   = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, 5-8 data bits, optional
// parity, 1 or 2 stop bits, frames sent back-to-back.
//   clock_i, reset_n_i    clock, async active-low reset
//   bus (slave)           write_i/data_i in, full_o/level_o/overflow_o out
//   data_bits_i           0..3 -> 5..8 data bits
//   parity_bit_i          parity enable; parity_even_i selects even parity
//   two_stop_bits_i       two stop bits
//   clock_divider_i       cycles per bit (0 behaves as 1)
//   break_i               break request (only with UART_TX_BREAK_EN defined)
//   serial_o              registered TX line, idles high
//   busy_o                high unless idle with an empty FIFO
// Build option: define UART_TX_BREAK_EN to build the BREAK state.
//
// state         | meaning
// ST_POST_RESET | line high for POST_RESET_BITS live bit periods
// ST_IDLE       | line high, waiting for data or break
// ST_SEND       | shifting out a frame
// ST_BREAK      | line low while break_i, then one high bit period
module uart_tx_buffered #(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  uart_tx_buffered_if.slave              bus,
  input  logic [1:0]                     data_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           two_stop_bits_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           break_i,
  output logic                           serial_o,
  output logic                           busy_o
);
  import uart_pkg::*;

  localparam int W       = CLOCK_DIVIDER_WIDTH;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [W-1:0] DIV_ONE = W'(1);

  state_t             state, state_n;
  logic [W-1:0]       timer, timer_n, div_lat, div_n, n_live;
  logic [3:0]         cnt, cnt_n, d_cnt, frame_len;
  logic [10:0]        shreg, shreg_n;
  logic               serial, serial_n, overflow_q;
  logic               pop, full, empty, par, tick, choose;
  logic [7:0]         head;
  logic [11:0]        frame;
  logic [LEVEL_W-1:0] level;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push      (bus.write_i),
    .push_data (bus.data_i),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign n_live = (clock_divider_i == '0) ? DIV_ONE : clock_divider_i;
  assign tick   = (timer == '0);

  // Whole frame assembled LSB-first from the FIFO head and the live format;
  // unused upper positions stay 1 and serve as stop bits.
  always_comb begin
    d_cnt    = data_bit_count(data_bits_i);
    frame    = '1;
    frame[0] = 1'b0;
    par      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < d_cnt) begin
        frame[i+1] = head[i];
        par        = par ^ head[i];
      end
    end
    if (parity_bit_i) frame[d_cnt + 4'd1] = parity_even_i ? par : ~par;
    frame_len = 4'd2 + d_cnt + {3'b000, parity_bit_i} + {3'b000, two_stop_bits_i};
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    div_n    = div_lat;
    cnt_n    = cnt;
    shreg_n  = shreg;
    serial_n = serial;
    pop      = 1'b0;
    choose   = 1'b0;
    case (state)
      ST_POST_RESET: begin
        if (!tick) timer_n = timer - DIV_ONE;
        else if (cnt == 4'd0) choose = 1'b1;
        else begin
          cnt_n   = cnt - 4'd1;
          timer_n = n_live - DIV_ONE;
        end
      end
      ST_IDLE: choose = 1'b1;
      ST_SEND: begin
        if (!tick) timer_n = timer - DIV_ONE;
        else if (cnt != 4'd0) begin
          serial_n = shreg[0];
          shreg_n  = {1'b1, shreg[10:1]};
          cnt_n    = cnt - 4'd1;
          timer_n  = div_lat - DIV_ONE;
        end else choose = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      // cnt 0: holding low; cnt 1: released, timing the high bit period.
      ST_BREAK: begin
        if (cnt == 4'd0) begin
          if (!break_i) begin
            serial_n = 1'b1;
            cnt_n    = 4'd1;
            timer_n  = div_lat - DIV_ONE;
          end
        end else if (!tick) timer_n = timer - DIV_ONE;
        else state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    // Shared decision for IDLE, end of quiet period and frame boundaries.
    if (choose) begin
      state_n  = ST_IDLE;
      serial_n = 1'b1;
`ifdef UART_TX_BREAK_EN
      if (break_i) begin
        state_n  = ST_BREAK;
        serial_n = 1'b0;
        cnt_n    = 4'd0;
        div_n    = n_live;
      end else
`endif
      if (!empty) begin
        pop      = 1'b1;
        state_n  = ST_SEND;
        serial_n = 1'b0;
        shreg_n  = frame[11:1];
        cnt_n    = frame_len - 4'd1;
        timer_n  = n_live - DIV_ONE;
        div_n    = n_live;
      end
    end
  end

`ifndef UART_TX_BREAK_EN
  logic break_unused;
  assign break_unused = break_i;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= ST_POST_RESET;
      timer      <= '0;
      div_lat    <= DIV_ONE;
      cnt        <= 4'(POST_RESET_BITS);
      shreg      <= '1;
      serial     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      div_lat    <= div_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      serial     <= serial_n;
      overflow_q <= bus.write_i & full & ~pop;
    end
  end

  assign serial_o       = serial;
  assign bus.full_o     = full;
  assign bus.level_o    = level;
  assign bus.overflow_o = overflow_q;
  assign busy_o         = ~reset_n_i | (state != ST_IDLE) | ~empty;
endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic [1:0]    data_bits_i;
  logic          parity_bit_i, parity_even_i, two_stop_bits_i, break_i;
  logic [DW-1:0] clock_divider_i;
  logic          serial_o, busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_buffered #(.CLOCK_DIVIDER_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .bus             (bus),
    .data_bits_i     (data_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .two_stop_bits_i (two_stop_bits_i),
    .clock_divider_i (clock_divider_i),
    .break_i         (break_i),
    .serial_o        (serial_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called with the current sample being sample 'skip' of the frame.
  task automatic check_frame(input string tag, input logic [11:0] bits,
                             input int len, input int n, input int skip);
    for (int s = skip; s < len * n; s++) begin
      chk($sformatf("%s bit%0d", tag, s / n), 32'(serial_o), 32'(bits[s / n]));
      tick();
    end
  endtask

  // Write at edge k: line still high after k, start bit from k+1.
  task automatic send_frame(input string tag, input logic [7:0] d,
                            input logic [11:0] bits, input int len, input int n);
    bus.write_i = 1'b1;
    bus.data_i  = d;
    tick();
    bus.write_i = 1'b0;
    chk({tag, " pre-start"}, 32'(serial_o), 32'd1);
    tick();
    check_frame(tag, bits, len, n, 0);
  endtask

  initial begin
    reset_n_i       = 1'b0;
    bus.write_i     = 1'b0;
    bus.data_i      = 8'h00;
    data_bits_i     = 2'd3;
    parity_bit_i    = 1'b0;
    parity_even_i   = 1'b0;
    two_stop_bits_i = 1'b0;
    clock_divider_i = 16'd4;
    break_i         = 1'b0;
    repeat (3) tick();

    chk("rst serial",   32'(serial_o),       32'd1);
    chk("rst level",    32'(bus.level_o),    32'd0);
    chk("rst full",     32'(bus.full_o),     32'd0);
    chk("rst overflow", 32'(bus.overflow_o), 32'd0);
    chk("rst busy",     32'(busy_o),         32'd1);

    // Quiet period: 12 bits x 4 cycles, then 0x55 8N1.
    reset_n_i   = 1'b1;
    bus.write_i = 1'b1;
    bus.data_i  = 8'h55;
    tick();
    bus.write_i = 1'b0;
    for (int i = 0; i < 48; i++) begin
      chk("quiet", 32'(serial_o), 32'd1);
      tick();
    end
    check_frame("f55", {2'b11, 1'b1, 8'h55, 1'b0}, 10, 4, 0);
    chk("f55 idle serial", 32'(serial_o), 32'd1);
    chk("f55 idle busy",   32'(busy_o),   32'd0);

    // Back-to-back frames, divider 2.
    clock_divider_i = 16'd2;
    bus.write_i = 1'b1;
    bus.data_i  = 8'hA5;
    tick();
    chk("b2b latency high", 32'(serial_o), 32'd1);
    bus.data_i = 8'h3C;
    tick();
    chk("b2b start", 32'(serial_o), 32'd0);
    bus.data_i = 8'hFF;
    tick();
    bus.write_i = 1'b0;
    check_frame("b2b A5", {2'b11, 1'b1, 8'hA5, 1'b0}, 10, 2, 1);
    check_frame("b2b 3C", {2'b11, 1'b1, 8'h3C, 1'b0}, 10, 2, 0);
    chk("b2b busy mid", 32'(busy_o), 32'd1);
    check_frame("b2b FF", {2'b11, 1'b1, 8'hFF, 1'b0}, 10, 2, 0);
    chk("b2b busy end", 32'(busy_o),    32'd0);
    chk("b2b level",    32'(bus.level_o), 32'd0);

    // Formats, divider 3. Bit 7 of 0x83 is not sent in 7-bit mode, so the
    // parity covers 0000011 only (even -> 0, odd -> 1).
    clock_divider_i = 16'd3;
    data_bits_i     = 2'd2;
    parity_bit_i    = 1'b1;
    parity_even_i   = 1'b1;
    two_stop_bits_i = 1'b1;
    send_frame("7E2", 8'h83, {1'b1, 1'b1, 1'b1, 1'b0, 7'h03, 1'b0}, 11, 3);
    parity_even_i = 1'b0;
    send_frame("7O2", 8'h83, {1'b1, 1'b1, 1'b1, 1'b1, 7'h03, 1'b0}, 11, 3);
    data_bits_i   = 2'd3;
    parity_even_i = 1'b1;
    send_frame("8E2", 8'h83, {1'b1, 1'b1, 1'b1, 8'h83, 1'b0}, 12, 3);
    data_bits_i     = 2'd1;
    parity_even_i   = 1'b0;
    two_stop_bits_i = 1'b0;
    send_frame("6O1", 8'h41, {3'b111, 1'b1, 1'b0, 6'h01, 1'b0}, 9, 3);

    // Divider 0 behaves as 1.
    clock_divider_i = 16'd0;
    data_bits_i     = 2'd3;
    parity_bit_i    = 1'b0;
    send_frame("div0", 8'h5A, {2'b11, 1'b1, 8'h5A, 1'b0}, 10, 1);

    // Format/divider changed after the start bit: current frame unchanged.
    clock_divider_i = 16'd3;
    bus.write_i = 1'b1;
    bus.data_i  = 8'h96;
    tick();
    bus.write_i = 1'b0;
    tick();
    clock_divider_i = 16'd7;
    data_bits_i     = 2'd0;
    parity_bit_i    = 1'b1;
    two_stop_bits_i = 1'b1;
    check_frame("midchg", {2'b11, 1'b1, 8'h96, 1'b0}, 10, 3, 0);
    // Next frame uses the new format: 5 bits 10110 (xor 1), odd parity -> 0.
    send_frame("5O2", 8'h96, {3'b111, 1'b1, 1'b1, 1'b0, 5'h16, 1'b0}, 9, 7);

    // Overflow: 18 writes at divider 100.
    clock_divider_i = 16'd100;
    data_bits_i     = 2'd3;
    parity_bit_i    = 1'b0;
    two_stop_bits_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      int exp_lvl;
      exp_lvl = (i == 0) ? 1 : ((i > 16) ? 16 : i);
      bus.write_i = 1'b1;
      bus.data_i  = 8'(i);
      tick();
      chk($sformatf("ovf level w%0d", i), 32'(bus.level_o), 32'(exp_lvl));
      chk($sformatf("ovf full w%0d", i), 32'(bus.full_o), (exp_lvl == 16) ? 32'd1 : 32'd0);
      chk($sformatf("ovf pulse w%0d", i), 32'(bus.overflow_o), (i == 17) ? 32'd1 : 32'd0);
    end
    bus.write_i = 1'b0;
    tick();
    chk("ovf pulse end", 32'(bus.overflow_o), 32'd0);
    chk("ovf level end", 32'(bus.level_o),    32'd16);

    // Write while full coinciding with the pop at the end of frame 0.
    repeat (982) tick();
    chk("full stop bit", 32'(serial_o),    32'd1);
    chk("full level",    32'(bus.level_o), 32'd16);
    bus.write_i = 1'b1;
    bus.data_i  = 8'hC3;
    tick();
    bus.write_i = 1'b0;
    chk("full+pop level",    32'(bus.level_o),    32'd16);
    chk("full+pop overflow", 32'(bus.overflow_o), 32'd0);
    chk("full+pop start",    32'(serial_o),       32'd0);

    // Asynchronous reset in the middle of a start bit.
    repeat (49) tick();
    chk("pre-reset serial", 32'(serial_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    chk("mid-rst serial",   32'(serial_o),       32'd1);
    chk("mid-rst level",    32'(bus.level_o),    32'd0);
    chk("mid-rst full",     32'(bus.full_o),     32'd0);
    chk("mid-rst overflow", 32'(bus.overflow_o), 32'd0);
    chk("mid-rst busy",     32'(busy_o),         32'd1);
    tick();
    tick();

    // Quiet period follows the live divider (1), FIFO came back flushed.
    clock_divider_i = 16'd1;
    reset_n_i   = 1'b1;
    bus.write_i = 1'b1;
    bus.data_i  = 8'h3C;
    tick();
    bus.write_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("quiet2", 32'(serial_o), 32'd1);
      tick();
    end
    check_frame("post-rst 3C", {2'b11, 1'b1, 8'h3C, 1'b0}, 10, 1, 0);
    chk("post-rst busy",  32'(busy_o),      32'd0);
    chk("post-rst level", 32'(bus.level_o), 32'd0);

    clock_divider_i = 16'd2;
`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame: frame completes, then low, then one high bit.
    bus.write_i = 1'b1;
    bus.data_i  = 8'hA5;
    tick();
    bus.write_i = 1'b0;
    tick();
    break_i = 1'b1;
    check_frame("brk frame", {2'b11, 1'b1, 8'hA5, 1'b0}, 10, 2, 0);
    for (int i = 0; i < 5; i++) begin
      chk("brk low",  32'(serial_o), 32'd0);
      chk("brk busy", 32'(busy_o),   32'd1);
      tick();
    end
    break_i = 1'b0;
    tick();
    chk("brk release hi0", 32'(serial_o), 32'd1);
    tick();
    chk("brk release hi1", 32'(serial_o), 32'd1);
    tick();
    chk("brk idle serial", 32'(serial_o), 32'd1);
    chk("brk idle busy",   32'(busy_o),   32'd0);
`else
    // Without the break build, break_i changes nothing.
    break_i = 1'b1;
    send_frame("nobrk", 8'h55, {2'b11, 1'b1, 8'h55, 1'b0}, 10, 2);
    for (int i = 0; i < 6; i++) begin
      chk("nobrk idle", 32'(serial_o), 32'd1);
      tick();
    end
    chk("nobrk busy", 32'(busy_o), 32'd0);
    break_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
